game_screen_sequencer: RTL and testbench

- Owns the OLED pixel bus and selects which of NUM_SCREENS game-screen generators drives it.
- Screen generators are combinational x/y → RGB565 blocks; all are presented in parallel on a flattened bus.
- Navigation button pulses request a screen change. The change is applied frame-synchronously as a left-to-right column wipe with a white seam.
- Sits between the screen generators and the OLED driver, which supplies x, y and frame_begin.

---
 rtl/game_screen_sequencer.sv | 152 +++++++++++++++
 tb/tb_game_screen_sequencer.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/game_screen_sequencer.sv
// Selects which screen generator drives the OLED pixel bus. A navigation request
// becomes a frame-synchronous left-to-right column wipe with a white seam.
module game_screen_sequencer #(
    parameter int NUM_SCREENS = 9,
    parameter int WIPE_STEP   = 12,
    parameter int SCREEN_W    = 96,
    parameter int SCREEN_H    = 64
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      frame_begin,
    input  logic [6:0]                x,
    input  logic [5:0]                y,
    input  logic                      btn_next,
    input  logic                      btn_prev,
    input  logic                      btn_home,
    input  logic [16*NUM_SCREENS-1:0] screen_data,
    output logic [15:0]               oled_data,
    output logic [3:0]                cur_screen,
    output logic                      busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        WIPE    = 2'd2
    } state_t;

    localparam logic [3:0] LAST_IDX = 4'(NUM_SCREENS - 1);
    localparam logic [7:0] STEP8    = 8'(WIPE_STEP);
    localparam logic [7:0] W8       = 8'(SCREEN_W);
    localparam logic [6:0] H7       = 7'(SCREEN_H);

    state_t      state_q, state_d;
    logic [3:0]  cur_screen_q, cur_screen_d;
    logic [3:0]  target_q, target_d;
    logic [6:0]  boundary_q, boundary_d;
    logic [15:0] oled_data_q, oled_data_d;
    logic        busy_q, busy_d;

    logic [3:0]  req_target;
    logic        req_valid;
    logic [7:0]  boundary_sum;
    logic [15:0] screen_pix [NUM_SCREENS];

    for (genvar g = 0; g < NUM_SCREENS; g++) begin : g_unpack
        assign screen_pix[g] = screen_data[16*g +: 16];
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            cur_screen_q <= 4'd0;
            target_q     <= 4'd0;
            boundary_q   <= 7'd0;
            oled_data_q  <= 16'h0000;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cur_screen_q <= cur_screen_d;
            target_q     <= target_d;
            boundary_q   <= boundary_d;
            oled_data_q  <= oled_data_d;
            busy_q       <= busy_d;
        end
    end

    // Request resolution and next-state logic
    always_comb begin
        state_d      = state_q;
        cur_screen_d = cur_screen_q;
        target_d     = target_q;
        boundary_d   = boundary_q;
        req_valid    = 1'b0;
        req_target   = cur_screen_q;
        boundary_sum = {1'b0, boundary_q} + STEP8;

        // Home wins; simultaneous next+prev cancel each other
        if (btn_home) begin
            req_valid  = 1'b1;
            req_target = 4'd0;
        end else if (btn_next ^ btn_prev) begin
            req_valid = 1'b1;
            if (btn_next) begin
                req_target = (cur_screen_q == LAST_IDX) ? 4'd0 : cur_screen_q + 4'd1;
            end else begin
                req_target = (cur_screen_q == 4'd0) ? LAST_IDX : cur_screen_q - 4'd1;
            end
        end else begin
            req_valid  = 1'b0;
            req_target = cur_screen_q;
        end

        case (state_q)
            IDLE: begin
                if (req_valid && (req_target != cur_screen_q)) begin
                    target_d = req_target;
                    state_d  = PENDING;
                end else begin
                    state_d = IDLE;
                end
            end
            PENDING: begin
                if (frame_begin) begin
                    boundary_d = STEP8[6:0];
                    state_d    = WIPE;
                end else begin
                    state_d = PENDING;
                end
            end
            WIPE: begin
                if (frame_begin) begin
                    if (boundary_sum >= W8) begin
                        cur_screen_d = target_q;
                        boundary_d   = 7'd0;
                        state_d      = IDLE;
                    end else begin
                        boundary_d = boundary_sum[6:0];
                        state_d    = WIPE;
                    end
                end else begin
                    state_d = WIPE;
                end
            end
            default: begin
                state_d    = IDLE;
                boundary_d = 7'd0;
            end
        endcase
    end

    // Pixel selection: blank outside the panel, seam at the boundary, new screen left of it
    always_comb begin
        oled_data_d = screen_pix[cur_screen_q];
        busy_d      = (state_d != IDLE);
        if (({1'b0, x} >= W8) || ({1'b0, y} >= H7)) begin
            oled_data_d = 16'h0000;
        end else if ((state_q == WIPE) && (x == boundary_q)) begin
            oled_data_d = 16'hFFFF;
        end else if ((state_q == WIPE) && (x < boundary_q)) begin
            oled_data_d = screen_pix[target_q];
        end else begin
            oled_data_d = screen_pix[cur_screen_q];
        end
    end

    assign oled_data  = oled_data_q;
    assign cur_screen = cur_screen_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_game_screen_sequencer.sv
// Randomised and directed bench for game_screen_sequencer; a reference model
// predicts each registered output and a monitor compares it one edge later.
module tb_game_screen_sequencer;

    localparam int NS   = 9;
    localparam int STEP = 12;
    localparam int W    = 96;
    localparam int H    = 64;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              frame_begin = 1'b0;
    logic              btn_next = 1'b0;
    logic              btn_prev = 1'b0;
    logic              btn_home = 1'b0;
    logic [6:0]        x = 7'd0;
    logic [5:0]        y = 6'd0;
    logic [16*NS-1:0]  screen_data;
    logic [15:0]       oled_data;
    logic [3:0]        cur_screen;
    logic              busy;

    game_screen_sequencer #(
        .NUM_SCREENS(NS), .WIPE_STEP(STEP), .SCREEN_W(W), .SCREEN_H(H)
    ) dut (
        .clk(clk), .reset(reset), .frame_begin(frame_begin), .x(x), .y(y),
        .btn_next(btn_next), .btn_prev(btn_prev), .btn_home(btn_home),
        .screen_data(screen_data), .oled_data(oled_data),
        .cur_screen(cur_screen), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] px;
        logic [3:0]  cur;
        logic        bsy;
    } exp_t;

    exp_t q[$];

    // Reference model: screen indices, a wipe frame counter and a busy flag
    int m_cur = 0, m_tgt = 0, m_frame = 0;
    bit m_busy = 1'b0, m_wipe = 1'b0;
    bit rand_sd = 1'b0;
    int n_pass = 0, n_total = 0;

    function automatic logic [15:0] slice(input int i);
        return screen_data[16*i +: 16];
    endfunction

    task automatic cyc(input bit r, input bit fb, input bit bn, input bit bp, input bit bh,
                       input int xx, input int yy);
        exp_t e;
        int   req;
        int   b;
        @(negedge clk);
        reset = r; frame_begin = fb; btn_next = bn; btn_prev = bp; btn_home = bh;
        x = 7'(xx); y = 6'(yy);
        if (rand_sd) begin
            for (int i = 0; i < NS; i++) screen_data[16*i +: 16] = 16'($urandom);
        end
        b = m_frame * STEP;
        if (r) e.px = 16'h0000;
        else if (xx >= W || yy >= H) e.px = 16'h0000;
        else if (m_wipe && xx == b) e.px = 16'hFFFF;
        else if (m_wipe && xx < b) e.px = slice(m_tgt);
        else e.px = slice(m_cur);

        if (r) begin
            m_cur = 0; m_tgt = 0; m_frame = 0; m_busy = 1'b0; m_wipe = 1'b0;
        end else if (!m_busy) begin
            req = -1;
            if (bh) req = 0;
            else if (bn && !bp) req = (m_cur + 1) % NS;
            else if (bp && !bn) req = (m_cur + NS - 1) % NS;
            if (req >= 0 && req != m_cur) begin
                m_tgt = req; m_busy = 1'b1; m_wipe = 1'b0;
            end
        end else if (!m_wipe) begin
            if (fb) begin m_wipe = 1'b1; m_frame = 1; end
        end else if (fb) begin
            if ((m_frame + 1) * STEP >= W) begin
                m_cur = m_tgt; m_busy = 1'b0; m_wipe = 1'b0; m_frame = 0;
            end else begin
                m_frame++;
            end
        end
        e.cur = 4'(m_cur);
        e.bsy = m_busy;
        q.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, $urandom_range(0, 127), $urandom_range(0, 63));
    endtask

    task automatic press(input bit bn, input bit bp, input bit bh);
        cyc(1'b0, 1'b0, bn, bp, bh, $urandom_range(0, 127), $urandom_range(0, 63));
    endtask

    // One frame: the pulse, then probes either side of the seam and at the panel edges
    task automatic frame();
        int b;
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, $urandom_range(0, 127), $urandom_range(0, 63));
        b = m_frame * STEP;
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, (b > 0) ? b - 1 : 0, 5);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, b, 10);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, b + 1, 20);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 100, 3);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 63);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 95, 0);
    endtask

    task automatic full_wipe();
        repeat (8) frame();
        idle(2);
    endtask

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Monitor: every registered output is compared one step after its edge
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                check("oled_data", oled_data, e.px);
                check("cur_screen", {12'h000, cur_screen}, {12'h000, e.cur});
                check("busy", {15'h0000, busy}, {15'h0000, e.bsy});
            end
        end
    end

    initial begin
        for (int i = 0; i < NS; i++) screen_data[16*i +: 16] = 16'(16'h1000 * i + i);

        repeat (3) cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5, 5);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5, 5);
        idle(3);

        press(1'b1, 1'b0, 1'b0);           // 0 -> 1
        idle(2);
        full_wipe();
        press(1'b0, 1'b0, 1'b1);           // 1 -> 0
        full_wipe();
        press(1'b0, 1'b1, 1'b0);           // 0 -> 8
        full_wipe();
        press(1'b1, 1'b0, 1'b0);           // 8 -> 0 wrap
        full_wipe();

        press(1'b1, 1'b1, 1'b0); idle(3);  // cancelled pair
        press(1'b0, 1'b0, 1'b1); idle(3);  // home at home
        repeat (3) begin press(1'b1, 1'b0, 1'b0); full_wipe(); end
        press(1'b1, 1'b0, 1'b1);           // home beats next at 3
        full_wipe();

        press(1'b1, 1'b0, 1'b0);           // presses during the wipe are ignored
        repeat (7) begin frame(); press(1'b1, 1'b0, 1'b0); press(1'b0, 1'b1, 1'b0); end
        frame();
        idle(2);

        cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 7, 7);   // request on frame_begin
        idle(3);
        full_wipe();

        press(1'b1, 1'b0, 1'b0);           // abort at boundary 48
        repeat (4) frame();
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 48, 10);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 48, 10);
        idle(3);

        rand_sd = 1'b1;
        repeat (3000) begin
            cyc(($urandom_range(0, 499) == 0), ($urandom_range(0, 9) == 0),
                ($urandom_range(0, 19) == 0), ($urandom_range(0, 19) == 0),
                ($urandom_range(0, 39) == 0),
                $urandom_range(0, 127), $urandom_range(0, 63));
        end

        repeat (3) @(posedge clk);
        #2;
        n_total++;
        if (q.size() == 0) n_pass++;
        else $display("FAIL drain: %0d expectations left, expected 0", q.size());

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
